control_sequencer: RTL and testbench

// Hardwired control unit driving the datapath's bus-select, register-enable and ALU-op inputs.

---
 rtl/control_sequencer_if.sv | 43 ++++
 rtl/control_sequencer.sv | 157 +++++++++++++++
 tb/tb_control_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Control-unit <-> datapath signal bundle: IR feedback in, bus/register/ALU controls out.
// mem_rdy exists only when CTRL_MEM_WAIT_EN is defined.
interface control_sequencer_if #(parameter int OPW = 5);
    logic [31:0]    ir;
    logic           branch_flag;
`ifdef CTRL_MEM_WAIT_EN
    logic           mem_rdy;
`endif
    // bus drivers
    logic PCout, Zlowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout;
    // register load enables
    logic MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHIin, ZLOin;
    // general-purpose register file select/enable
    logic Gra, Grb, Grc, Rin, Rout, BAout;
    // miscellaneous strobes
    logic IncPC, Read, Write, CONin, OutPortin;
    logic [OPW-1:0] operation;
    logic           run;

    modport master (
        input  ir, branch_flag,
`ifdef CTRL_MEM_WAIT_EN
        input  mem_rdy,
`endif
        output PCout, Zlowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout,
        output MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHIin, ZLOin,
        output Gra, Grb, Grc, Rin, Rout, BAout,
        output IncPC, Read, Write, CONin, OutPortin,
        output operation, run
    );

    modport slave (
        output ir, branch_flag,
`ifdef CTRL_MEM_WAIT_EN
        output mem_rdy,
`endif
        input  PCout, Zlowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout,
        input  MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHIin, ZLOin,
        input  Gra, Grb, Grc, Rin, Rout, BAout,
        input  IncPC, Read, Write, CONin, OutPortin,
        input  operation, run
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch T0-T2, opcode-specific execute T3-T7, HALT until clr.
// Optional CTRL_MEM_WAIT_EN: T1, ld T6 and st T7 stretch until mem_rdy.
module control_sequencer #(
    parameter int OPW = 5
) (
    input  logic                clk,
    input  logic                clr,
    control_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        K_NOP, K_LD, K_LDI, K_ST, K_ALU, K_IMM, K_MULDIV, K_UNARY,
        K_BR, K_JR, K_IN, K_OUT, K_MFHI, K_MFLO, K_HALT
    } kind_t;

    localparam logic [OPW-1:0] OP_ADD = OPW'(5'b00011);

    state_t         state;
    kind_t          kind;
    logic [OPW-1:0] opcode;
    logic           mem_ok;

    assign opcode = bus.ir[31 -: OPW];

    // Only the opcode field steers sequencing; operand fields go straight to the datapath.
    logic unused_ir_bits;
    assign unused_ir_bits = ^bus.ir[31-OPW:0];

`ifdef CTRL_MEM_WAIT_EN
    assign mem_ok = bus.mem_rdy;
`else
    assign mem_ok = 1'b1;
`endif

    function automatic kind_t classify(input logic [OPW-1:0] op);
        case (op) inside
            5'b00000:          return K_LD;
            5'b00001:          return K_LDI;
            5'b00010:          return K_ST;
            [5'b00011:5'b01011]: return K_ALU;
            [5'b01100:5'b01110]: return K_IMM;
            5'b01111, 5'b10000: return K_MULDIV;
            5'b10001, 5'b10010: return K_UNARY;
            5'b10011:          return K_BR;
            5'b10100:          return K_JR;
            5'b10110:          return K_IN;
            5'b10111:          return K_OUT;
            5'b11000:          return K_MFHI;
            5'b11001:          return K_MFLO;
            5'b11011:          return K_HALT;
            default:           return K_NOP;
        endcase
    endfunction

    assign kind = classify(opcode);

    // NOTE: clr is sampled on the clock edge (synchronous), and all state updates use <= so
    // every read in this block sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= S_RST;
        end else begin
            case (state)
                S_RST:  state <= S_T0;
                S_T0:   state <= S_T1;
                S_T1:   if (mem_ok) state <= S_T2;
                S_T2:   state <= (kind == K_HALT) ? S_HALT :
                                 (kind == K_NOP)  ? S_T0   : S_T3;
                S_T3:   state <= (kind inside {K_JR, K_IN, K_OUT, K_MFHI, K_MFLO}) ? S_T0 : S_T4;
                S_T4:   state <= (kind == K_UNARY) ? S_T0 : S_T5;
                S_T5:   state <= (kind inside {K_LD, K_ST, K_MULDIV, K_BR}) ? S_T6 : S_T0;
                S_T6: begin
                    if (kind == K_ST)      state <= S_T7;
                    else if (kind == K_LD) state <= mem_ok ? S_T7 : S_T6;
                    else                   state <= S_T0;
                end
                S_T7:   if (kind != K_ST || mem_ok) state <= S_T0;
                S_HALT: state <= S_HALT;
                default: state <= S_RST;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path leaves one unassigned
    // (that would infer a latch).
    always_comb begin
        bus.PCout = 1'b0; bus.Zlowout = 1'b0; bus.ZHighout = 1'b0; bus.MDRout = 1'b0;
        bus.HIout = 1'b0; bus.LOout = 1'b0; bus.InPortout = 1'b0; bus.Cout = 1'b0;
        bus.MARin = 1'b0; bus.PCin = 1'b0; bus.MDRin = 1'b0; bus.IRin = 1'b0; bus.Yin = 1'b0;
        bus.HIin = 1'b0; bus.LOin = 1'b0; bus.ZHIin = 1'b0; bus.ZLOin = 1'b0;
        bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0; bus.Rin = 1'b0; bus.Rout = 1'b0;
        bus.BAout = 1'b0; bus.IncPC = 1'b0; bus.Read = 1'b0; bus.Write = 1'b0;
        bus.CONin = 1'b0; bus.OutPortin = 1'b0;
        bus.operation = '0;
        bus.run = (state != S_RST) && (state != S_HALT);

        case (state)
            S_T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.ZLOin = 1'b1; end
            S_T1: begin bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1; end
            S_T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
            S_T3: case (kind)
                K_ALU, K_IMM:      begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
                K_LD, K_LDI, K_ST: begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
                K_MULDIV:          begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
                K_UNARY: begin
                    bus.Grb = 1'b1; bus.Rout = 1'b1; bus.ZLOin = 1'b1; bus.operation = opcode;
                end
                K_BR:   begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1; end
                K_JR:   begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
                K_IN:   begin bus.InPortout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                K_OUT:  begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OutPortin = 1'b1; end
                K_MFHI: begin bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                K_MFLO: begin bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                default: ;
            endcase
            S_T4: case (kind)
                K_ALU: begin
                    bus.Grc = 1'b1; bus.Rout = 1'b1; bus.ZLOin = 1'b1; bus.operation = opcode;
                end
                K_IMM:             begin bus.Cout = 1'b1; bus.ZLOin = 1'b1; bus.operation = opcode; end
                K_LD, K_LDI, K_ST: begin bus.Cout = 1'b1; bus.ZLOin = 1'b1; bus.operation = OP_ADD; end
                K_MULDIV: begin
                    bus.Grb = 1'b1; bus.Rout = 1'b1; bus.ZLOin = 1'b1; bus.ZHIin = 1'b1;
                    bus.operation = opcode;
                end
                K_UNARY: begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                K_BR:    begin bus.PCout = 1'b1; bus.Yin = 1'b1; end
                default: ;
            endcase
            S_T5: case (kind)
                K_ALU, K_IMM, K_LDI: begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                K_LD, K_ST:          begin bus.Zlowout = 1'b1; bus.MARin = 1'b1; end
                K_MULDIV:            begin bus.Zlowout = 1'b1; bus.LOin = 1'b1; end
                K_BR:    begin bus.Cout = 1'b1; bus.ZLOin = 1'b1; bus.operation = OP_ADD; end
                default: ;
            endcase
            S_T6: case (kind)
                K_LD:     begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
                K_ST:     begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1; end
                K_MULDIV: begin bus.ZHighout = 1'b1; bus.HIin = 1'b1; end
                K_BR:     begin bus.Zlowout = 1'b1; bus.PCin = bus.branch_flag; end
                default: ;
            endcase
            S_T7: case (kind)
                K_LD:    begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                K_ST:    bus.Write = 1'b1;
                default: ;
            endcase
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: table of instruction sequences plus
// hand-written reset, halt, clear-mid-instruction and (with CTRL_MEM_WAIT_EN) memory-wait cases.
module tb_control_sequencer;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    control_sequencer_if bus();
    control_sequencer dut (.clk(clk), .clr(clr), .bus(bus));

    localparam logic [27:0] PCOUT = 28'd1 << 0,  ZLOWOUT = 28'd1 << 1,  ZHIGHOUT = 28'd1 << 2;
    localparam logic [27:0] MDROUT = 28'd1 << 3, HIOUT = 28'd1 << 4,    LOOUT = 28'd1 << 5;
    localparam logic [27:0] INPORTOUT = 28'd1 << 6, COUT = 28'd1 << 7,  MARIN = 28'd1 << 8;
    localparam logic [27:0] PCIN = 28'd1 << 9,   MDRIN = 28'd1 << 10,   IRIN = 28'd1 << 11;
    localparam logic [27:0] YIN = 28'd1 << 12,   HIIN = 28'd1 << 13,    LOIN = 28'd1 << 14;
    localparam logic [27:0] ZHIIN = 28'd1 << 15, ZLOIN = 28'd1 << 16,   GRA = 28'd1 << 17;
    localparam logic [27:0] GRB = 28'd1 << 18,   GRC = 28'd1 << 19,     RIN = 28'd1 << 20;
    localparam logic [27:0] ROUT = 28'd1 << 21,  BAOUT = 28'd1 << 22,   INCPC = 28'd1 << 23;
    localparam logic [27:0] READ = 28'd1 << 24,  WRITE = 28'd1 << 25,   CONIN = 28'd1 << 26;
    localparam logic [27:0] OUTPORTIN = 28'd1 << 27;
    localparam logic [33:0] Z = '0;

    // {run, operation, 28 control bits}
    logic [33:0] act;
    assign act = {bus.run, bus.operation,
                  bus.OutPortin, bus.CONin, bus.Write, bus.Read, bus.IncPC, bus.BAout, bus.Rout,
                  bus.Rin, bus.Grc, bus.Grb, bus.Gra, bus.ZLOin, bus.ZHIin, bus.LOin, bus.HIin,
                  bus.Yin, bus.IRin, bus.MDRin, bus.PCin, bus.MARin, bus.Cout, bus.InPortout,
                  bus.LOout, bus.HIout, bus.MDRout, bus.ZHighout, bus.Zlowout, bus.PCout};

    typedef struct packed {
        logic [31:0]       ir;
        logic              bf;
        logic [2:0]        n;
        logic [4:0][33:0]  step;
    } vec_t;

    vec_t        vecs[$];
    logic [33:0] sb[$];
    logic [33:0] f0, f1, f2;
    int          tests = 0;
    int          fails = 0;

    function automatic logic [33:0] w(input logic [27:0] c, input logic [4:0] op);
        return {1'b1, op, c};
    endfunction

    function automatic logic [31:0] irw(input logic [4:0] op);
        return {op, 27'h0ABCDEF};
    endfunction

    task automatic add_vec(input logic [31:0] ir, input logic bf, input int n,
                           input logic [33:0] s0, input logic [33:0] s1, input logic [33:0] s2,
                           input logic [33:0] s3, input logic [33:0] s4);
        vec_t v;
        v.ir = ir; v.bf = bf; v.n = 3'(n);
        v.step[0] = s0; v.step[1] = s1; v.step[2] = s2; v.step[3] = s3; v.step[4] = s4;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [33:0] got, input logic [33:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Pop one expected word, compare mid-cycle, then advance to just after the next edge.
    task automatic step(input string name);
        logic [33:0] e;
        @(negedge clk);
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: scoreboard empty, got %h", name, act);
        end else begin
            e = sb.pop_front();
            check(name, act, e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] op;
        logic [33:0] rt3, imm3, ldx3, ldx4, wb, md3;
        clr = 1'b1;
        bus.ir = '0;
        bus.branch_flag = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
        bus.mem_rdy = 1'b1;
`endif
        f0 = w(PCOUT | MARIN | INCPC | ZLOIN, 5'd0);
        f1 = w(ZLOWOUT | PCIN | READ | MDRIN, 5'd0);
        f2 = w(MDROUT | IRIN, 5'd0);
        rt3  = w(GRB | ROUT | YIN, 5'd0);
        imm3 = rt3;
        ldx3 = w(GRB | BAOUT | YIN, 5'd0);
        ldx4 = w(COUT | ZLOIN, 5'b00011);
        wb   = w(ZLOWOUT | GRA | RIN, 5'd0);
        md3  = w(GRA | ROUT | YIN, 5'd0);

        add_vec(32'h28918000, 1'b0, 3, rt3, w(GRC | ROUT | ZLOIN, 5'b00101), wb, Z, Z);
        foreach (vecs[i]) ;
        for (int k = 0; k < 3; k++) begin
            op = (k == 0) ? 5'b00011 : (k == 1) ? 5'b00100 : 5'b01011;
            add_vec(irw(op), 1'b0, 3, rt3, w(GRC | ROUT | ZLOIN, op), wb, Z, Z);
        end
        add_vec(irw(5'b01100), 1'b0, 3, imm3, w(COUT | ZLOIN, 5'b01100), wb, Z, Z);
        add_vec(irw(5'b01110), 1'b0, 3, imm3, w(COUT | ZLOIN, 5'b01110), wb, Z, Z);
        add_vec(irw(5'b00001), 1'b0, 3, ldx3, ldx4, wb, Z, Z);
        add_vec(irw(5'b00000), 1'b0, 5, ldx3, ldx4, w(ZLOWOUT | MARIN, 5'd0),
                w(READ | MDRIN, 5'd0), w(MDROUT | GRA | RIN, 5'd0));
        add_vec(irw(5'b00010), 1'b0, 5, ldx3, ldx4, w(ZLOWOUT | MARIN, 5'd0),
                w(GRA | ROUT | MDRIN, 5'd0), w(WRITE, 5'd0));
        add_vec(irw(5'b10000), 1'b0, 4, md3, w(GRB | ROUT | ZLOIN | ZHIIN, 5'b10000),
                w(ZLOWOUT | LOIN, 5'd0), w(ZHIGHOUT | HIIN, 5'd0), Z);
        add_vec(irw(5'b01111), 1'b0, 4, md3, w(GRB | ROUT | ZLOIN | ZHIIN, 5'b01111),
                w(ZLOWOUT | LOIN, 5'd0), w(ZHIGHOUT | HIIN, 5'd0), Z);
        add_vec(irw(5'b10001), 1'b0, 2, w(GRB | ROUT | ZLOIN, 5'b10001), wb, Z, Z, Z);
        add_vec(irw(5'b10010), 1'b0, 2, w(GRB | ROUT | ZLOIN, 5'b10010), wb, Z, Z, Z);
        for (int b = 0; b < 2; b++)
            add_vec(irw(5'b10011), 1'(b), 4, w(GRA | ROUT | CONIN, 5'd0), w(PCOUT | YIN, 5'd0),
                    w(COUT | ZLOIN, 5'b00011), w(ZLOWOUT | ((b == 1) ? PCIN : 28'd0), 5'd0), Z);
        add_vec(irw(5'b10100), 1'b0, 1, w(GRA | ROUT | PCIN, 5'd0), Z, Z, Z, Z);
        add_vec(irw(5'b10110), 1'b0, 1, w(INPORTOUT | GRA | RIN, 5'd0), Z, Z, Z, Z);
        add_vec(irw(5'b10111), 1'b0, 1, w(GRA | ROUT | OUTPORTIN, 5'd0), Z, Z, Z, Z);
        add_vec(irw(5'b11000), 1'b0, 1, w(HIOUT | GRA | RIN, 5'd0), Z, Z, Z, Z);
        add_vec(irw(5'b11001), 1'b0, 1, w(LOOUT | GRA | RIN, 5'd0), Z, Z, Z, Z);
        add_vec(irw(5'b11010), 1'b0, 0, Z, Z, Z, Z, Z);
        add_vec(irw(5'b10101), 1'b0, 0, Z, Z, Z, Z, Z);
        add_vec(irw(5'b11111), 1'b0, 0, Z, Z, Z, Z, Z);

        // Reset: clr high across two edges, then one RST cycle before fetch.
        @(posedge clk);
        #1;
        sb.push_back(Z); step("reset_hold");
        clr = 1'b0;
        sb.push_back(Z); step("reset_rst");

        foreach (vecs[i]) begin
            bus.ir = vecs[i].ir;
            bus.branch_flag = vecs[i].bf;
            sb.push_back(f0); sb.push_back(f1); sb.push_back(f2);
            for (int k = 0; k < int'(vecs[i].n); k++) sb.push_back(vecs[i].step[k]);
            for (int k = 0; k < 3 + int'(vecs[i].n); k++)
                step($sformatf("vec%0d_op%b_cyc%0d", i, vecs[i].ir[31:27], k));
        end

        // halt: parked with everything low until clr.
        bus.ir = irw(5'b11011);
        sb.push_back(f0); sb.push_back(f1); sb.push_back(f2);
        for (int k = 0; k < 10; k++) sb.push_back(Z);
        for (int k = 0; k < 13; k++) step($sformatf("halt_cyc%0d", k));
        clr = 1'b1;
        sb.push_back(Z); step("halt_clr");
        clr = 1'b0;
        sb.push_back(Z); step("halt_rst");

`ifdef CTRL_MEM_WAIT_EN
        // ld with memory stalling three cycles in T6.
        bus.ir = irw(5'b00000);
        sb.push_back(f0); sb.push_back(f1); sb.push_back(f2);
        sb.push_back(ldx3); sb.push_back(ldx4); sb.push_back(w(ZLOWOUT | MARIN, 5'd0));
        for (int k = 0; k < 6; k++) step($sformatf("ldwait_cyc%0d", k));
        bus.mem_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(w(READ | MDRIN, 5'd0));
            step($sformatf("ldwait_stall%0d", k));
        end
        bus.mem_rdy = 1'b1;
        sb.push_back(w(READ | MDRIN, 5'd0)); step("ldwait_release");
        sb.push_back(w(MDROUT | GRA | RIN, 5'd0)); step("ldwait_t7");
        sb.push_back(f0); sb.push_back(f1); sb.push_back(f2);
        for (int k = 0; k < 3; k++) step($sformatf("ldwait_next%0d", k));
        bus.ir = irw(5'b11010);
`endif

        // mul aborted by clr during T4: LOin/HIin must never appear.
        bus.ir = irw(5'b10000);
        sb.push_back(f0); sb.push_back(f1); sb.push_back(f2); sb.push_back(md3);
        for (int k = 0; k < 4; k++) step($sformatf("mulclr_cyc%0d", k));
        clr = 1'b1;
        sb.push_back(w(GRB | ROUT | ZLOIN | ZHIIN, 5'b10000)); step("mulclr_t4");
        clr = 1'b0;
        sb.push_back(Z); step("mulclr_rst");
        sb.push_back(f0); step("mulclr_t0");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
